regfile_wb_arbiter: RTL

//   Shares the single register-file write port between two writeback requesters
//   (A = ALU result, B = load/return unit) using round-robin valid/ready arbitration.

---
 rtl/regfile_wb_arbiter_if.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 75 +++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between the two writeback requesters, the issue logic and the arbiter.
// The arbiter takes the slave modport; the requester side takes master.
interface regfile_wb_arbiter_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
);
  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic              a_valid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_data;
  logic              a_ready;
  logic              b_valid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_data;
  logic              b_ready;
  logic              claim_valid;
  logic [ADDR_W-1:0] claim_addr;
  logic              claim_ready;
  logic [NREGS-1:0]  pending;
  logic              rf_w_en;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data, claim_valid, claim_addr,
    output a_ready, b_ready, claim_ready, pending, rf_w_en, rf_write_addr, rf_write_data
  );

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data, claim_valid, claim_addr,
    input  a_ready, b_ready, claim_ready, pending, rf_w_en, rf_write_addr, rf_write_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered write
// stage and a pending-write scoreboard that issue logic uses to reserve destinations.
module regfile_wb_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  regfile_wb_arbiter_if.slave bus
);
  localparam int unsigned NREGS = 2 ** ADDR_W;
  localparam logic [NREGS-1:0] NonZeroMask = {{(NREGS - 1){1'b1}}, 1'b0};

  logic              w_grant_a;
  logic              w_grant_b;
  logic              w_claim_ready;
  logic [NREGS-1:0]  w_set;
  logic [NREGS-1:0]  w_clr;

  logic              r_last_b;
  logic              r_w_en;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic [NREGS-1:0]  r_pending;

  // Readies are held low while in reset so nothing handshakes against a dropped stage.
  always_comb begin
    w_grant_a     = rst_n & bus.a_valid & (~bus.b_valid | r_last_b);
    w_grant_b     = rst_n & bus.b_valid & (~bus.a_valid | ~r_last_b);
    w_claim_ready = rst_n & bus.claim_valid &
                    ((bus.claim_addr == '0) | ~r_pending[bus.claim_addr]);
    w_set = '0;
    if (w_claim_ready && (bus.claim_addr != '0)) w_set[bus.claim_addr] = 1'b1;
    w_clr = '0;
    if (r_w_en) w_clr[r_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_b  <= 1'b1;
      r_w_en    <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_pending <= '0;
    end else begin
      // Set is applied after clear so a fresh reservation survives a same-edge write.
      r_pending <= ((r_pending & ~w_clr) | w_set) & NonZeroMask;
      if (w_grant_a) begin
        r_last_b <= 1'b0;
        r_w_en   <= (bus.a_addr != '0);
        if (bus.a_addr != '0) begin
          r_addr <= bus.a_addr;
          r_data <= bus.a_data;
        end
      end else if (w_grant_b) begin
        r_last_b <= 1'b1;
        r_w_en   <= (bus.b_addr != '0);
        if (bus.b_addr != '0) begin
          r_addr <= bus.b_addr;
          r_data <= bus.b_data;
        end
      end else begin
        r_w_en <= 1'b0;
      end
    end
  end

  assign bus.a_ready       = w_grant_a;
  assign bus.b_ready       = w_grant_b;
  assign bus.claim_ready   = w_claim_ready;
  assign bus.pending       = r_pending;
  assign bus.rf_w_en       = r_w_en;
  assign bus.rf_write_addr = r_addr;
  assign bus.rf_write_data = r_data;
endmodule
